// File: rtl/rf_debug_reader_pkg.sv
// Shared definitions for the register-file debug reader: default geometry,
// FSM state encoding and a small state-classification helper.
// Optional feature macro (see rf_debug_reader): RF_DEBUG_SKIP_ZERO_EN.
package rf_debug_reader_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Everything except IDLE counts as an active scan.
  function automatic logic state_is_busy(input state_e s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/rf_debug_addr_ctr.sv
// Scan address tracker for rf_debug_reader: holds the current and last
// register address of a scan, provides the wrapping successor of the
// current address and flags when the current address is the last one.
module rf_debug_addr_ctr import rf_debug_reader_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_cur,
  input  logic [ADDR_W-1:0] load_last,
  input  logic              advance,
  output logic [ADDR_W-1:0] cur,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last_hit
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] next_s;

  // Successor address wraps explicitly so NUM_REGS need not be a power of two.
  always_comb begin
    if (cur_q == LAST_IDX) begin
      next_s = ADDR_ZERO;
    end else begin
      next_s = cur_q + ADDR_ONE;
    end
  end

  // Load a new range on scan start, otherwise step or hold the current address.
  always_comb begin
    cur_d  = cur_q;
    last_d = last_q;
    if (load) begin
      cur_d  = load_cur;
      last_d = load_last;
    end else if (advance) begin
      cur_d  = next_s;
    end else begin
      cur_d  = cur_q;
    end
  end

  // Address registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= ADDR_ZERO;
      last_q <= ADDR_ZERO;
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
    end
  end

  assign cur       = cur_q;
  assign next_addr = next_s;
  assign last_hit  = (cur_q == last_q);

endmodule

// File: rtl/rf_debug_reader.sv
// Register-file debug reader: on a start pulse walks an inclusive, wrapping
// address range over the debug read port (ra2/rd2) and emits each register
// as an {addr, data} sample over a valid/ready handshake.
// Optional feature: define RF_DEBUG_SKIP_ZERO_EN to suppress samples whose
// register value is zero (they are neither emitted nor counted).
module rf_debug_reader import rf_debug_reader_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ra2_q, ra2_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic              ctr_load_s;
  logic              ctr_adv_s;
  logic [ADDR_W-1:0] ctr_cur_s;
  logic [ADDR_W-1:0] ctr_next_s;
  logic              ctr_last_s;

  rf_debug_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_addr_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load_s),
    .load_cur  (start_addr),
    .load_last (end_addr),
    .advance   (ctr_adv_s),
    .cur       (ctr_cur_s),
    .next_addr (ctr_next_s),
    .last_hit  (ctr_last_s)
  );

  // Next-state and next-output computation; ra2 is kept equal to the scan
  // address so the register file presents the right data during READ.
  always_comb begin
    state_d    = state_q;
    ra2_d      = ra2_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    count_d    = count_q;
    ctr_load_s = 1'b0;
    ctr_adv_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ctr_load_s = 1'b1;
          ra2_d      = start_addr;
          count_d    = CNT_ZERO;
          state_d    = S_READ;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_READ: begin
`ifdef RF_DEBUG_SKIP_ZERO_EN
        if (rd2 == DATA_ZERO) begin
          if (ctr_last_s) begin
            state_d   = S_FIN;
          end else begin
            ctr_adv_s = 1'b1;
            ra2_d     = ctr_next_s;
            state_d   = S_READ;
          end
        end else begin
          out_addr_d = ctr_cur_s;
          out_data_d = rd2;
          state_d    = S_SEND;
        end
`else
        out_addr_d = ctr_cur_s;
        out_data_d = rd2;
        state_d    = S_SEND;
`endif
      end
      S_SEND: begin
        if (out_ready) begin
          count_d = count_q + CNT_ONE;
          if (ctr_last_s) begin
            state_d   = S_FIN;
          end else begin
            ctr_adv_s = 1'b1;
            ra2_d     = ctr_next_s;
            state_d   = S_READ;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs follow the state being entered so they are registered
    // and line up with it exactly.
    out_valid_d = (state_d == S_SEND);
    busy_d      = state_is_busy(state_d);
    done_d      = (state_d == S_FIN);
  end

  // State and output registers with synchronous reset; reset drops any pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ra2_q       <= ADDR_ZERO;
      out_valid_q <= 1'b0;
      out_addr_q  <= ADDR_ZERO;
      out_data_q  <= DATA_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      ra2_q       <= ra2_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign ra2       = ra2_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rf_debug_reader.sv
// Directed self-checking bench for rf_debug_reader. A small register-file
// array drives rd2 from ra2. Expected sample lists are written by hand, with
// alternatives when RF_DEBUG_SKIP_ZERO_EN is defined.
module tb_rf_debug_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  start_addr;
  logic [4:0]  end_addr;
  logic [4:0]  ra2;
  logic [31:0] rd2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [5:0]  count;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int          got_cyc  [$];
  logic [4:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  int          done_cyc;
  int          done_cnt;

  rf_debug_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .ra2        (ra2),
    .rd2        (rd2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Asynchronous debug read port of the modelled register file.
  always_comb rd2 = rf[ra2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic exp_push(input logic [4:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic do_start(input logic [4:0] sa, input logic [4:0] ea);
    start      = 1'b1;
    start_addr = sa;
    end_addr   = ea;
    tick();
    start      = 1'b0;
  endtask

  // Observe the current cycle, then advance; stop at the done pulse.
  task automatic collect(input int budget);
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
        got_cyc.push_back(i);
      end
      if (done) begin
        done_cnt++;
        done_cyc = i;
        break;
      end
      tick();
    end
    check("done_within_budget", 64'(done_cnt), 64'd1);
  endtask

  task automatic compare_samples(input string tag);
    int n;
    check({tag, "_nsamp"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
  endtask

  // After FIN: one more cycle returns to IDLE with the final count held.
  task automatic check_end(input string tag, input logic [5:0] exp_count);
    check({tag, "_count_fin"}, 64'(count), 64'(exp_count));
    tick();
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_count_idle"}, 64'(count), 64'(exp_count));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[2]  = 32'h0000_2ffc;
    rf[3]  = 32'h0000_1800;
    rf[4]  = 32'hdead_0004;
    rf[5]  = 32'h0000_0505;
    rf[30] = 32'h3000_0030;
    rf[31] = 32'h3100_0031;

    rst        = 1'b1;
    start      = 1'b0;
    start_addr = 5'd0;
    end_addr   = 5'd0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_valid",     64'(out_valid), 64'd0);
    check("rst_ra2",       64'(ra2),       64'd0);
    check("rst_out_addr",  64'(out_addr),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_count",     64'(count),     64'd0);
    rst = 1'b0;
    tick();

    // Scan 0..3 with a consumer that is always ready.
    do_start(5'd0, 5'd3);
    check("s03_busy", 64'(busy), 64'd1);
    check("s03_ra2_read", 64'(ra2), 64'd0);
    collect(200);
    exp_clear();
`ifdef RF_DEBUG_SKIP_ZERO_EN
    exp_push(5'd2, 32'h0000_2ffc);
    exp_push(5'd3, 32'h0000_1800);
    compare_samples("s03");
    check_end("s03", 6'd2);
`else
    exp_push(5'd0, 32'h0000_0000);
    exp_push(5'd1, 32'h0000_0000);
    exp_push(5'd2, 32'h0000_2ffc);
    exp_push(5'd3, 32'h0000_1800);
    compare_samples("s03");
    check("s03_first_cyc", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'd1);
    check("s03_last_cyc", 64'(got_cyc.size() > 3 ? got_cyc[3] : -1), 64'd7);
    check("s03_done_cyc", 64'(done_cyc), 64'd8);
    check_end("s03", 6'd4);
`endif

    // Wrapping scan 30..1.
    do_start(5'd30, 5'd1);
    collect(200);
    exp_clear();
    exp_push(5'd30, 32'h3000_0030);
    exp_push(5'd31, 32'h3100_0031);
`ifdef RF_DEBUG_SKIP_ZERO_EN
    compare_samples("s30_1");
    check_end("s30_1", 6'd2);
`else
    exp_push(5'd0, 32'h0000_0000);
    exp_push(5'd1, 32'h0000_0000);
    compare_samples("s30_1");
    check_end("s30_1", 6'd4);
`endif
    check("s30_1_cyc1", 64'(got_cyc.size() > 1 ? got_cyc[1] : -1), 64'd3);

    // Back-pressure: consumer stalls for 5 cycles on register 2.
    out_ready = 1'b0;
    do_start(5'd2, 5'd3);
    tick();
    for (k = 0; k < 5; k++) begin
      check($sformatf("stall_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("stall_addr%0d", k),  64'(out_addr),  64'd2);
      check($sformatf("stall_data%0d", k),  64'(out_data),  64'h2ffc);
      tick();
    end
    check("stall_count", 64'(count), 64'd0);
    out_ready = 1'b1;
    collect(200);
    exp_clear();
    exp_push(5'd2, 32'h0000_2ffc);
    exp_push(5'd3, 32'h0000_1800);
    compare_samples("stall");
    check_end("stall", 6'd2);

    // Second start while busy is ignored.
    do_start(5'd4, 5'd6);
    start      = 1'b1;
    start_addr = 5'd10;
    end_addr   = 5'd12;
    tick();
    start      = 1'b0;
    collect(200);
    exp_clear();
    exp_push(5'd4, 32'hdead_0004);
    exp_push(5'd5, 32'h0000_0505);
`ifdef RF_DEBUG_SKIP_ZERO_EN
    compare_samples("restart");
    check_end("restart", 6'd2);
`else
    exp_push(5'd6, 32'h0000_0000);
    compare_samples("restart");
    check_end("restart", 6'd3);
`endif

    // Single-register scan 5..5.
    do_start(5'd5, 5'd5);
    check("s55_ra2_read", 64'(ra2), 64'd5);
    collect(200);
    exp_clear();
    exp_push(5'd5, 32'h0000_0505);
    compare_samples("s55");
    check("s55_first_cyc", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'd1);
    check("s55_done_cyc", 64'(done_cyc), 64'd2);
    check_end("s55", 6'd1);

    // Full scan 0..31: count must reach 32 in the default build.
    do_start(5'd0, 5'd31);
    collect(400);
    exp_clear();
    for (int a = 0; a < 32; a++) begin
`ifdef RF_DEBUG_SKIP_ZERO_EN
      if (rf[a] != 32'h0) exp_push(5'(a), rf[a]);
`else
      exp_push(5'(a), rf[a]);
`endif
    end
    compare_samples("full");
`ifdef RF_DEBUG_SKIP_ZERO_EN
    check_end("full", 6'd6);
`else
    check_end("full", 6'd32);
`endif

    // All-zero range 6..9.
    do_start(5'd6, 5'd9);
    collect(200);
    exp_clear();
`ifdef RF_DEBUG_SKIP_ZERO_EN
    compare_samples("zero");
    check_end("zero", 6'd0);
`else
    for (int a = 6; a <= 9; a++) exp_push(5'(a), 32'h0);
    compare_samples("zero");
    check_end("zero", 6'd4);
`endif

    // Reset in the middle of a scan: no done pulse, outputs back to reset values.
    do_start(5'd0, 5'd31);
    for (k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    check("mrst_busy",     64'(busy),      64'd0);
    check("mrst_valid",    64'(out_valid), 64'd0);
    check("mrst_done",     64'(done),      64'd0);
    check("mrst_count",    64'(count),     64'd0);
    check("mrst_out_addr", 64'(out_addr),  64'd0);
    check("mrst_out_data", 64'(out_data),  64'd0);
    check("mrst_ra2",      64'(ra2),       64'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (k = 0; k < 8; k++) begin
      if (done || out_valid || busy) done_cnt++;
      tick();
    end
    check("mrst_quiet", 64'(done_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
